dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the pipeline data memory (dmem).
- Port C is the CPU load/store unit. Port D is a secondary master (debug/DMA loader).
- Issues at most one access per cycle, tracks the one-cycle dmem read latency, returns read data to the owning port, and prevents starvation of port D.
- dmem's own rst is driven elsewhere; this block never asserts WE and RE together.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- STARVE_LIMIT, 4, consecutive denied cycles of d_req after which D is forced to win (range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- hold  in  1  blocks all new grants while high (e.g. dmem being cleared).
- c_req  in  1  C request valid; must stay high with stable fields until c_gnt.
- c_we  in  1  C write (1) / read (0).
- c_addr  in  AW  C address.
- c_wdata  in  DW  C write data.
- c_gnt  out  1  C request accepted this cycle.
- c_rvalid  out  1  C read data valid.
- c_rdata  out  DW  C read data.
- d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata: same as the C port, for D.
- mem_we  out  1  dmem WE.
- mem_re  out  1  dmem RE.
- mem_a  out  AW  dmem A.
- mem_wd  out  DW  dmem WD.
- mem_rd  in  DW  dmem RD (registered inside dmem).
- busy  out  1  a read response is pending, or any request is held off.

Behaviour:
- Reset (rst low, async): rd_pend=0, rd_owner=C, starve_cnt=0.
  - All gnt, rvalid, mem_we and mem_re are 0.
  - All rdata are 0; mem_a and mem_wd are 0.
  - Takes effect immediately, mid-transaction included.
  - A read granted in the cycle before reset asserts produces no response after reset.
- Grant logic is combinational from registered state and the current req inputs:
  - If hold=1: no grant.
  - Else if d_req && starve_cnt==STARVE_LIMIT: grant D.
  - Else if c_req: grant C.
  - Else if d_req: grant D.
  - Exactly one of c_gnt and d_gnt may be high in a cycle.
- Issue: in the grant cycle, mem_a, mem_wd and mem_we/mem_re are driven from the granted port.
  - mem_we = we; mem_re = !we.
  - With no grant: mem_we=mem_re=0; mem_a and mem_wd are 0.
- Read latency is exactly 1 cycle:
  - A read granted in cycle T sets rd_pend=1 and rd_owner=port at the T edge.
  - In cycle T+1, owner_rvalid=1 and owner_rdata=mem_rd. The non-owner rdata is 0.
- Writes complete at the grant edge and produce no response.
- Back-to-back issue:
  - A new grant is legal in the response cycle T+1 (full throughput).
  - rd_pend is reloaded every edge: 1 if a read was granted, else 0.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each cycle with d_req=1, d_gnt=0 and hold=0.
  - Clears to 0 on d_gnt or d_req=0.
  - Holds its value while hold=1.
- busy = rd_pend | (c_req & !c_gnt) | (d_req & !d_gnt).
- Requester dropping req before gnt: illegal. A protocol assertion is required in the bench; RTL behaviour is undefined.
- Address alignment is passed through unchanged; no checks.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - typedef enum logic {PORT_C, PORT_D} port_e;
  - typedef struct packed {logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata;} mem_req_t;
  - The default STARVE_LIMIT constant.
- One natural sub-module: arb_starve_ctr (saturating counter with clear/enable/hold), instantiated once.
- Grant, issue mux and response tracking stay in dmem_arbiter.

Test Plan:
1. Reset/idle:
   - Stimulus: rst low, then high, with no requests for 5 cycles.
   - Response: all gnt/rvalid/mem_we/mem_re stay 0; rdata=0; busy=0.
2. C write then read:
   - Stimulus: c_we=1, addr 0x100, wdata 0xCAFEF00D, then a C read of 0x100.
   - Response: c_gnt in each request cycle; c_rvalid exactly one cycle after the read grant with c_rdata=0xCAFEF00D; d_rvalid stays 0.
3. Back-to-back reads, alternating owners:
   - Stimulus: C read 0x10 in cycle 1, D read 0x20 in cycle 2, with mem preloaded 0x11/0x22.
   - Response: cycle 2 c_rvalid, c_rdata=0x11; cycle 3 d_rvalid, d_rdata=0x22.
4. Starvation, STARVE_LIMIT=4:
   - Stimulus: c_req and d_req held continuously.
   - Response: C is granted on cycles 1–4; D is granted on cycle 5; the counter clears; C wins again on cycle 6.
5. hold:
   - Stimulus: hold=1 for 3 cycles with c_req=1.
   - Response: no grants; mem_re=mem_we=0; busy=1; starve_cnt unchanged. Grant occurs in the first cycle after hold drops.
6. Reset mid-read:
   - Stimulus: D read granted, then rst low before the next edge completes the response cycle.
   - Response: d_rvalid is 0 immediately; no response appears after rst returns high; starve_cnt=0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Latency: n/a (types only). Backpressure: n/a.
package dmem_arb_pkg;

  localparam int PKG_AW           = 32;
  localparam int PKG_DW           = 32;
  localparam int STARVE_LIMIT_DEF = 4;
  // Wide enough for the largest legal STARVE_LIMIT (15).
  localparam int STARVE_CNT_W     = 4;

  typedef enum logic {PORT_C, PORT_D} port_e;

  typedef struct packed {
    logic              we;
    logic [PKG_AW-1:0] addr;
    logic [PKG_DW-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive cycles port D was refused; flags the limit.
// Latency: count updates at the edge after the refused cycle. Backpressure: frozen while hold is high.
module arb_starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int LIMIT = STARVE_LIMIT_DEF,
  parameter int W     = STARVE_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         req,
  input  logic         gnt,
  output logic [W-1:0] cnt,
  output logic         at_limit
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (hold) begin
      cnt_d = cnt_q;
    end else if (!req || gnt) begin
      cnt_d = '0;
    end else if (cnt_q < W'(LIMIT)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt      = cnt_q;
  assign at_limit = (cnt_q == W'(LIMIT));

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (C = LSU, D = debug/DMA) arbiter and sequencer in front of dmem.
// Latency: issue in the grant cycle, read data exactly one cycle later. Backpressure: req waits for gnt; hold blocks all grants.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW           = PKG_AW,
  parameter int DW           = PKG_DW,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,

  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,

  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,

  output logic          mem_we,
  output logic          mem_re,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd,

  output logic          busy
);

  logic                    grant_en;
  logic                    d_force;
  logic                    any_gnt;
  logic                    starve_at_limit;
  logic [STARVE_CNT_W-1:0] starve_cnt;
  mem_req_t                issue_req;

  logic  rd_pend_d;
  logic  rd_pend_q;
  port_e rd_owner_d;
  port_e rd_owner_q;

  // Grants are gated by rst so nothing leaks onto dmem while reset is held.
  always_comb begin
    grant_en = rst & ~hold;
    d_force  = d_req & starve_at_limit;
    d_gnt    = grant_en & d_req & (starve_at_limit | ~c_req);
    c_gnt    = grant_en & c_req & ~d_force;
    any_gnt  = c_gnt | d_gnt;
  end

  always_comb begin
    issue_req = '0;
    if (c_gnt) begin
      issue_req.we    = c_we;
      issue_req.addr  = c_addr;
      issue_req.wdata = c_wdata;
    end else if (d_gnt) begin
      issue_req.we    = d_we;
      issue_req.addr  = d_addr;
      issue_req.wdata = d_wdata;
    end
  end

  assign mem_we = any_gnt &  issue_req.we;
  assign mem_re = any_gnt & ~issue_req.we;
  assign mem_a  = issue_req.addr;
  assign mem_wd = issue_req.wdata;

  // Pending flag is reloaded every edge, so a new read may issue in the response cycle.
  always_comb begin
    rd_pend_d  = mem_re;
    rd_owner_d = rd_owner_q;
    if (mem_re) begin
      rd_owner_d = d_gnt ? PORT_D : PORT_C;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= PORT_C;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign c_rvalid = rd_pend_q & (rd_owner_q == PORT_C);
  assign d_rvalid = rd_pend_q & (rd_owner_q == PORT_D);
  assign c_rdata  = c_rvalid ? mem_rd : '0;
  assign d_rdata  = d_rvalid ? mem_rd : '0;

  assign busy = rd_pend_q | (c_req & ~c_gnt) | (d_req & ~d_gnt);

  arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT),
    .W     (STARVE_CNT_W)
  ) u_starve_ctr (
    .clk      (clk),
    .rst      (rst),
    .hold     (hold),
    .req      (d_req),
    .gnt      (d_gnt),
    .cnt      (starve_cnt),
    .at_limit (starve_at_limit)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural one-cycle dmem model.
// Latency: n/a. Backpressure: requesters hold req until gnt, checked by a protocol monitor.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        hold;
  logic        c_req, c_we;
  logic [31:0] c_addr, c_wdata;
  logic        c_gnt, c_rvalid;
  logic [31:0] c_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_we, mem_re;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:1023];
  logic        c_wait, d_wait;

  dmem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .hold     (hold),
    .c_req    (c_req),
    .c_we     (c_we),
    .c_addr   (c_addr),
    .c_wdata  (c_wdata),
    .c_gnt    (c_gnt),
    .c_rvalid (c_rvalid),
    .c_rdata  (c_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .mem_we   (mem_we),
    .mem_re   (mem_re),
    .mem_a    (mem_a),
    .mem_wd   (mem_wd),
    .mem_rd   (mem_rd),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // dmem model: write at the edge, registered read data
  always @(posedge clk) begin
    if (mem_we) mem[mem_a[11:2]] <= mem_wd;
    if (mem_re) mem_rd <= mem[mem_a[11:2]];
  end

  // Requester protocol: req must not drop while waiting for gnt
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_wait <= 1'b0;
      d_wait <= 1'b0;
    end else begin
      assert (!(c_wait && !c_req)) else $error("protocol: c_req dropped before c_gnt");
      assert (!(d_wait && !d_req)) else $error("protocol: d_req dropped before d_gnt");
      c_wait <= c_req & ~c_gnt;
      d_wait <= d_req & ~d_gnt;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    hold  = 0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 0;
    c_req = 1; c_we = 0; c_addr = 32'h44;
    #2;
    total++;
    if ({c_gnt, d_gnt, mem_re, mem_we} !== 4'b0) begin
      bad++; $display("FAIL reset_gate: gnt/mem=%b want 0000", {c_gnt, d_gnt, mem_re, mem_we});
    end
    total++;
    if (mem_a !== 32'h0 || mem_wd !== 32'h0) begin
      bad++; $display("FAIL reset_bus: mem_a=%h mem_wd=%h want 0", mem_a, mem_wd);
    end
    total++;
    if (dut.starve_cnt !== 4'd0) begin
      bad++; $display("FAIL reset_cnt: starve_cnt=%0d want 0", dut.starve_cnt);
    end
    tick();
    c_req = 0;
    tick();
    rst = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if ({c_gnt, d_gnt, c_rvalid, d_rvalid, mem_we, mem_re, busy} !== 7'b0 ||
          c_rdata !== 32'h0 || d_rdata !== 32'h0) begin
        bad++;
        $display("FAIL idle_%0d: ctl=%b c_rdata=%h d_rdata=%h want all 0", i,
                 {c_gnt, d_gnt, c_rvalid, d_rvalid, mem_we, mem_re, busy}, c_rdata, d_rdata);
      end
      tick();
    end
  endtask

  task automatic test_c_write_read;
    c_req = 1; c_we = 1; c_addr = 32'h100; c_wdata = 32'hCAFEF00D;
    #1;
    total++;
    if ({c_gnt, d_gnt, mem_we, mem_re} !== 4'b1010 || mem_a !== 32'h100 || mem_wd !== 32'hCAFEF00D) begin
      bad++; $display("FAIL c_write_issue: gnt/we/re=%b a=%h wd=%h want 1010 100 cafef00d",
                      {c_gnt, d_gnt, mem_we, mem_re}, mem_a, mem_wd);
    end
    tick();
    c_we = 0; c_wdata = 0;
    #1;
    total++;
    if ({c_gnt, mem_we, mem_re, c_rvalid} !== 4'b1010 || mem_a !== 32'h100) begin
      bad++; $display("FAIL c_read_issue: gnt/we/re/rvalid=%b a=%h want 1010 100",
                      {c_gnt, mem_we, mem_re, c_rvalid}, mem_a);
    end
    tick();
    c_req = 0;
    #1;
    total++;
    if (c_rvalid !== 1'b1 || c_rdata !== 32'hCAFEF00D) begin
      bad++; $display("FAIL c_read_resp: rvalid=%b rdata=%h want 1 cafef00d", c_rvalid, c_rdata);
    end
    total++;
    if (d_rvalid !== 1'b0 || d_rdata !== 32'h0 || busy !== 1'b1) begin
      bad++; $display("FAIL c_read_side: d_rvalid=%b d_rdata=%h busy=%b want 0 0 1", d_rvalid, d_rdata, busy);
    end
    tick();
    #1;
    total++;
    if (c_rvalid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL c_read_once: rvalid=%b busy=%b want 0 0", c_rvalid, busy);
    end
  endtask

  task automatic test_back_to_back;
    // preload through the arbiter
    c_req = 1; c_we = 1; c_addr = 32'h10; c_wdata = 32'h11;
    tick();
    c_addr = 32'h20; c_wdata = 32'h22;
    tick();
    c_we = 0; c_addr = 32'h10; c_wdata = 0;
    #1;
    total++;
    if (c_gnt !== 1'b1 || mem_re !== 1'b1 || mem_a !== 32'h10) begin
      bad++; $display("FAIL b2b_c_issue: gnt=%b re=%b a=%h want 1 1 10", c_gnt, mem_re, mem_a);
    end
    tick();
    c_req = 0; c_addr = 0;
    d_req = 1; d_we = 0; d_addr = 32'h20;
    #1;
    total++;
    if (c_rvalid !== 1'b1 || c_rdata !== 32'h11 || d_rdata !== 32'h0) begin
      bad++; $display("FAIL b2b_c_resp: c_rvalid=%b c_rdata=%h d_rdata=%h want 1 11 0", c_rvalid, c_rdata, d_rdata);
    end
    total++;
    if (d_gnt !== 1'b1 || c_gnt !== 1'b0 || mem_re !== 1'b1 || mem_a !== 32'h20) begin
      bad++; $display("FAIL b2b_d_issue: d_gnt=%b c_gnt=%b re=%b a=%h want 1 0 1 20", d_gnt, c_gnt, mem_re, mem_a);
    end
    tick();
    d_req = 0; d_addr = 0;
    #1;
    total++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'h22 || c_rvalid !== 1'b0 || c_rdata !== 32'h0) begin
      bad++; $display("FAIL b2b_d_resp: d_rvalid=%b d_rdata=%h c_rvalid=%b c_rdata=%h want 1 22 0 0",
                      d_rvalid, d_rdata, c_rvalid, c_rdata);
    end
    tick();
  endtask

  task automatic test_starvation;
    int exp_cnt [6] = '{0, 1, 2, 3, 4, 0};
    c_req = 1; c_we = 0; c_addr = 32'h10;
    d_req = 1; d_we = 0; d_addr = 32'h20;
    for (int k = 1; k <= 6; k++) begin
      #1;
      total++;
      if (dut.starve_cnt !== 4'(exp_cnt[k-1])) begin
        bad++; $display("FAIL starve_cnt_c%0d: cnt=%0d want %0d", k, dut.starve_cnt, exp_cnt[k-1]);
      end
      total++;
      if (c_gnt !== (k != 5) || d_gnt !== (k == 5)) begin
        bad++; $display("FAIL starve_gnt_c%0d: c_gnt=%b d_gnt=%b want %b %b", k, c_gnt, d_gnt, k != 5, k == 5);
      end
      if (k == 6) begin
        total++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h22) begin
          bad++; $display("FAIL starve_d_resp: d_rvalid=%b d_rdata=%h want 1 22", d_rvalid, d_rdata);
        end
      end else if (k >= 2) begin
        total++;
        if (c_rvalid !== 1'b1 || c_rdata !== 32'h11) begin
          bad++; $display("FAIL starve_c_resp_c%0d: c_rvalid=%b c_rdata=%h want 1 11", k, c_rvalid, c_rdata);
        end
      end
      tick();
    end
    c_req = 0;
    #1;
    total++;
    if (d_gnt !== 1'b1 || dut.starve_cnt !== 4'd1 || c_rdata !== 32'h11) begin
      bad++; $display("FAIL starve_tail: d_gnt=%b cnt=%0d c_rdata=%h want 1 1 11", d_gnt, dut.starve_cnt, c_rdata);
    end
    tick();
    d_req = 0;
    #1;
    total++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'h22) begin
      bad++; $display("FAIL starve_tail_resp: d_rvalid=%b d_rdata=%h want 1 22", d_rvalid, d_rdata);
    end
    tick();
  endtask

  task automatic test_hold;
    c_req = 1; c_we = 1; c_addr = 32'h40; c_wdata = 32'h1;
    d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'h2;
    #1;
    total++;
    if (c_gnt !== 1'b1 || d_gnt !== 1'b0) begin
      bad++; $display("FAIL hold_pre: c_gnt=%b d_gnt=%b want 1 0", c_gnt, d_gnt);
    end
    tick();
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({c_gnt, d_gnt, mem_we, mem_re} !== 4'b0 || busy !== 1'b1 || dut.starve_cnt !== 4'd1) begin
        bad++; $display("FAIL hold_c%0d: gnt/we/re=%b busy=%b cnt=%0d want 0000 1 1", i,
                        {c_gnt, d_gnt, mem_we, mem_re}, busy, dut.starve_cnt);
      end
      tick();
    end
    hold = 0;
    #1;
    total++;
    if (c_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_we !== 1'b1 || dut.starve_cnt !== 4'd1) begin
      bad++; $display("FAIL hold_release: c_gnt=%b d_gnt=%b we=%b cnt=%0d want 1 0 1 1",
                      c_gnt, d_gnt, mem_we, dut.starve_cnt);
    end
    tick();
    c_req = 0;
    #1;
    total++;
    if (d_gnt !== 1'b1 || dut.starve_cnt !== 4'd2 || mem_a !== 32'h80) begin
      bad++; $display("FAIL hold_d_after: d_gnt=%b cnt=%0d a=%h want 1 2 80", d_gnt, dut.starve_cnt, mem_a);
    end
    tick();
    d_req = 0;
    #1;
    total++;
    if (dut.starve_cnt !== 4'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL hold_end: cnt=%0d busy=%b want 0 0", dut.starve_cnt, busy);
    end
    tick();
  endtask

  task automatic test_reset_mid_read;
    d_req = 1; d_we = 0; d_addr = 32'h20;
    #1;
    total++;
    if (d_gnt !== 1'b1 || mem_re !== 1'b1) begin
      bad++; $display("FAIL rmid_issue: d_gnt=%b re=%b want 1 1", d_gnt, mem_re);
    end
    tick();
    #1;
    total++;
    if (d_rvalid !== 1'b1) begin
      bad++; $display("FAIL rmid_pre: d_rvalid=%b want 1", d_rvalid);
    end
    rst = 0;
    d_req = 0; d_addr = 0;
    #1;
    total++;
    if (d_rvalid !== 1'b0 || d_rdata !== 32'h0 || dut.starve_cnt !== 4'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL rmid_async: d_rvalid=%b d_rdata=%h cnt=%0d busy=%b want 0 0 0 0",
                      d_rvalid, d_rdata, dut.starve_cnt, busy);
    end
    tick();
    tick();
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (d_rvalid !== 1'b0 || c_rvalid !== 1'b0 || d_rdata !== 32'h0) begin
        bad++; $display("FAIL rmid_after_%0d: d_rvalid=%b c_rvalid=%b d_rdata=%h want 0 0 0",
                        i, d_rvalid, c_rvalid, d_rdata);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_c_write_read();
    test_back_to_back();
    test_starvation();
    test_hold();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
